// File: rtl/serial_code_decoder_pkg.sv
// Shared definitions for the serial code decoder: FSM states, frame layout, line levels.
package serial_code_decoder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_CODE      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } state_t;

    // Frame bit positions, in transmission order
    localparam int unsigned POS_W = 3;
    localparam logic [POS_W-1:0] POS_START   = 3'd0;
    localparam logic [POS_W-1:0] POS_CODE_HI = 3'd1;
    localparam logic [POS_W-1:0] POS_CODE_LO = 3'd2;
    localparam logic [POS_W-1:0] POS_PARITY  = 3'd3;
    localparam logic [POS_W-1:0] POS_STOP    = 3'd4;

    // Line levels
    localparam logic LVL_IDLE  = 1'b1;
    localparam logic LVL_START = 1'b0;
    localparam logic LVL_STOP  = 1'b1;

    // One-hot decode of a 2-bit code: bit N set for code N
    function automatic logic [3:0] code_onehot(input logic [1:0] code);
        return 4'(4'b0001 << code);
    endfunction

endpackage

// File: rtl/serial_code_decoder_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle level.
module rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    import serial_code_decoder_pkg::*;

    logic r_meta;
    logic r_sync;

    // Double-register the line so downstream logic sees a stable level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= LVL_IDLE;
            r_sync <= LVL_IDLE;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/serial_code_decoder.sv
// Decodes start/code[1]/code[0]/even-parity/stop frames into a registered one-hot output.
module serial_code_decoder #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic out0,
    output logic out1,
    output logic out2,
    output logic out3,
    output logic valid,
    output logic err,
    output logic busy
);
    import serial_code_decoder_pkg::*;

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic             w_rx_s;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [POS_W-1:0] r_pos;
    logic [1:0]       r_code;
    logic             r_par;
    logic [3:0]       r_out;
    logic             r_valid;
    logic             r_err;
    logic             r_busy;

    rx_sync u_rx_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rx),
        .o_q (w_rx_s)
    );

    // Frame FSM: bit timing counter, sampling, parity/stop checks and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_pos   <= POS_START;
            r_code  <= 2'b00;
            r_par   <= 1'b0;
            r_out   <= 4'b0000;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_rx_s == LVL_START) begin
                        r_state <= ST_START;
                        r_cnt   <= '0;
                        r_pos   <= POS_START;
                        r_busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    // Re-check the line at mid start bit to reject glitches
                    if (r_cnt == CNT_MID) begin
                        r_cnt <= '0;
                        if (w_rx_s == LVL_START) begin
                            r_state <= ST_CODE;
                            r_pos   <= POS_CODE_HI;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_CODE: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
                        if (r_pos == POS_CODE_HI) begin
                            r_code[1] <= w_rx_s;
                            r_pos     <= POS_CODE_LO;
                        end else begin
                            r_code[0] <= w_rx_s;
                            r_pos     <= POS_PARITY;
                            r_state   <= ST_PARITY;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_par   <= w_rx_s;
                        r_pos   <= POS_STOP;
                        r_state <= ST_STOP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
                        if (w_rx_s == LVL_STOP) begin
                            if (r_par == (r_code[1] ^ r_code[0])) begin
                                r_out   <= code_onehot(r_code);
                                r_valid <= 1'b1;
                            end else begin
                                r_err <= 1'b1;
                            end
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            // Framing error: wait for the line to return idle before re-arming
                            r_err   <= 1'b1;
                            r_state <= ST_WAIT_HIGH;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_WAIT_HIGH: begin
                    if (w_rx_s == LVL_IDLE) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign out0  = r_out[0];
    assign out1  = r_out[1];
    assign out2  = r_out[2];
    assign out3  = r_out[3];
    assign valid = r_valid;
    assign err   = r_err;
    assign busy  = r_busy;

endmodule

// File: tb/tb_serial_code_decoder.sv
// Randomized self-checking bench for serial_code_decoder against a frame-level reference model.
module tb_serial_code_decoder;

    localparam int unsigned C = 4;

    logic clk = 1'b0;
    logic rst;
    logic rx;
    logic out0, out1, out2, out3;
    logic valid, err, busy;

    int n_checks = 0;
    int n_errors = 0;

    // Pulse observations collected by the monitor
    int         vcnt = 0;
    int         ecnt = 0;
    int         both = 0;
    logic [3:0] vq[$];

    // Reference model state: outputs expected after the frames seen so far
    logic [3:0] exp_out;

    serial_code_decoder #(.CLKS_PER_BIT(C)) dut (
        .clk   (clk),
        .rst   (rst),
        .rx    (rx),
        .out0  (out0),
        .out1  (out1),
        .out2  (out2),
        .out3  (out3),
        .valid (valid),
        .err   (err),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Count valid/err pulses on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (valid) begin
            vcnt = vcnt + 1;
            vq.push_back({out3, out2, out1, out0});
        end
        if (err) ecnt = ecnt + 1;
        if (valid && err) both = both + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_obs();
        vcnt = 0;
        ecnt = 0;
        vq.delete();
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick(C);
    endtask

    task automatic send_frame(input logic [1:0] code, input logic par, input logic stop);
        send_bit(1'b0);
        send_bit(code[1]);
        send_bit(code[0]);
        send_bit(par);
        send_bit(stop);
    endtask

    // Bounded wait for the decoder to return to idle
    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        tick(3);
        while (busy && k < 60) begin
            tick(1);
            k++;
        end
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Frame-level model: a good frame needs a high stop bit and even parity over the code
    task automatic run_frame(input string tag, input logic [1:0] code, input logic par,
                             input logic stop, input int low_hold);
        int exp_v;
        int exp_e;
        exp_v = (stop == 1'b1 && par == (code[1] ^ code[0])) ? 1 : 0;
        exp_e = 1 - exp_v;
        if (exp_v == 1) exp_out = 4'(1 << code);
        clear_obs();
        send_frame(code, par, stop);
        if (!stop) begin
            tick(low_hold);
            check({tag, "_wait_high"}, 32'(busy), 32'd1);
            rx = 1'b1;
        end
        wait_idle(tag);
        check({tag, "_valid_cnt"}, 32'(vcnt), 32'(exp_v));
        check({tag, "_err_cnt"}, 32'(ecnt), 32'(exp_e));
        check({tag, "_outs"}, 32'({out3, out2, out1, out0}), 32'(exp_out));
    endtask

    initial begin
        logic [1:0] code;
        logic       par;
        logic       stop;

        rst = 1'b1;
        rx  = 1'b1;
        exp_out = 4'b0000;
        tick(3);
        check("rst_outs", 32'({out3, out2, out1, out0}), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        rst = 1'b0;
        clear_obs();
        tick(20);
        check("idle_outs", 32'({out3, out2, out1, out0}), 32'd0);
        check("idle_pulses", 32'(vcnt + ecnt), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Four back-to-back good frames, codes 00..11
        clear_obs();
        for (int i = 0; i < 4; i++) begin
            code = 2'(i);
            send_frame(code, code[1] ^ code[0], 1'b1);
        end
        exp_out = 4'b1000;
        wait_idle("b2b");
        check("b2b_valid_cnt", 32'(vcnt), 32'd4);
        check("b2b_err_cnt", 32'(ecnt), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("b2b_out_%0d", i), (vq.size() > i) ? 32'(vq[i]) : 32'hFFFF_FFFF,
                  32'(1 << i));
        end

        // Bad parity: code 10 sent with parity 0
        run_frame("bad_par", 2'b10, 1'b0, 1'b1, 0);

        // Bad stop on code 01, line held low, then a good code 11
        run_frame("bad_stop", 2'b01, 1'b1, 1'b0, 10);
        tick(2);
        run_frame("after_stop", 2'b11, 1'b0, 1'b1, 0);

        // Single-cycle low glitch
        clear_obs();
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(10);
        check("glitch_pulses", 32'(vcnt + ecnt), 32'd0);
        check("glitch_busy", 32'(busy), 32'd0);
        check("glitch_outs", 32'({out3, out2, out1, out0}), 32'(exp_out));

        // Reset during the parity bit of code 11
        clear_obs();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rx = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(3);
        rx = 1'b1;
        tick(2);
        rst = 1'b0;
        exp_out = 4'b0000;
        tick(4);
        check("midrst_pulses", 32'(vcnt + ecnt), 32'd0);
        check("midrst_outs", 32'({out3, out2, out1, out0}), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        run_frame("after_rst", 2'b01, 1'b1, 1'b1, 0);

        // Random frames with occasional parity and stop faults
        for (int i = 0; i < 24; i++) begin
            code = 2'($urandom_range(0, 3));
            par  = (code[1] ^ code[0]) ^ ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 4) != 0);
            run_frame($sformatf("rnd%0d", i), code, par, stop, 5);
            tick(int'($urandom_range(1, 3)));
        end

        check("valid_err_overlap", 32'(both), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_code_decoder.md
SERIAL_CODE_DECODER -- requirements
Module: serial_code_decoder

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, meaning clock cycles per serial bit (even, >=4).
REQ-002 SHALL have port clk  input  1  rising-edge clock; the block has one clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port rx  input  1  serial code line, idle high, asynchronous to clk.
REQ-005 SHALL have ports out0..out3  output  1 each  registered one-hot decode of the last good code (out0 = code 00 ... out3 = code 11).
REQ-006 SHALL have port valid  output  1  one-cycle pulse when out0..out3 update.
REQ-007 SHALL have port err  output  1  one-cycle pulse on a parity or stop-bit failure.
REQ-008 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-009 SHALL accept frame: start(0), code[1], code[0], parity, stop(1); parity is even, so parity = code[1]^code[0]; each bit is CLKS_PER_BIT cycles.
REQ-010 SHALL pass rx through a 2-flop synchronizer reset to 1; all FSM decisions use the synchronized bit rx_s.
REQ-011 SHALL implement states IDLE, START, CODE, PARITY, STOP, WAIT_HIGH.
REQ-012 IDLE: rx_s==0 -> START, with the cycle counter cleared.
REQ-013 START: at counter == CLKS_PER_BIT/2-1, rx_s==0 -> CODE with the counter cleared; rx_s==1 -> IDLE (glitch: no err, no valid).
REQ-014 CODE: sample rx_s at every CLKS_PER_BIT-th count (mid-bit); first sample -> code[1], second -> code[0], then -> PARITY.
REQ-015 PARITY: sample after CLKS_PER_BIT counts -> STOP.
REQ-016 STOP: sample after CLKS_PER_BIT counts.
  - stop==1, parity ok: load out0..out3 and pulse valid on the next edge -> IDLE.
  - stop==1, parity bad: pulse err, outputs held -> IDLE.
  - stop==0: pulse err, outputs held -> WAIT_HIGH.
REQ-017 WAIT_HIGH: remain until rx_s==1 -> IDLE; no start is accepted here.
REQ-018 out0..out3 SHALL be exactly one-hot after the first good frame and hold their value between good frames.
REQ-019 valid and err SHALL never be high in the same cycle; each is a single-cycle pulse per frame.
REQ-020 Latency: valid/new outputs appear 1 cycle after the stop-bit sample edge, i.e. 2 + 4.5*CLKS_PER_BIT (+1) cycles after the rx falling edge.
REQ-021 The counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide and wrap to 0 at each bit sample; no free-running overflow.
REQ-022 Back-to-back frames (start immediately after stop) SHALL all be decoded.
REQ-023 A frame in progress ignores nothing but rx; there are no other inputs.

Reset
REQ-024 On rst=1 at a clk edge: FSM -> IDLE, counter=0, synchronizer=1, out0..out3=0, valid=0, err=0, busy=0.
REQ-025 rst mid-frame SHALL abort the frame with no valid/err; decoding restarts at the next falling edge after rst deasserts.
REQ-026 Before the first good frame all outN SHALL be 0 (the only permitted all-zero state).

Structure
REQ-027 A shared package SHALL hold the state encoding (6 states), the frame bit positions, and the idle/start/stop level constants.
REQ-028 One sub-module SHALL be used: rx_sync (2-flop synchronizer, reset value 1); the FSM, counter, and decode stay in serial_code_decoder.

Verification (CLKS_PER_BIT=4)
REQ-029 Reset, then rx idle 20 cycles -> out0..out3=0000, valid=0, err=0, busy=0.
REQ-030 Frames with codes 00, 01, 10, 11 (parity 0, 1, 1, 0) back-to-back -> four valid pulses; out3..out0 = 0001, 0010, 0100, 1000 in order; no err.
REQ-031 Code 10 with parity 0 -> err pulse, no valid, outputs keep the prior value.
REQ-032 Code 01 with stop=0, rx held low 10 cycles, then a good frame with code 11 -> err, FSM stays WAIT_HIGH while low, then valid with out3=1.
REQ-033 rx low for 1 cycle (glitch) -> returns to IDLE; no valid, no err.
REQ-034 rst asserted during the PARITY bit of code 11 -> outputs 0000, no pulses; a following good frame with code 01 -> out1=1, valid.
